audio_sample_bridge: RTL

//   Moves stereo samples between the codec core FIFOs and the filter bank.

---
 rtl/audio_sample_bridge_if.sv | 40 ++++
 rtl/audio_sample_bridge.sv | 129 ++++++++++++
 2 files changed

// File: rtl/audio_sample_bridge_if.sv
// Signal bundle between the bridge and its neighbours: codec ADC/DAC FIFOs and the filter bank.
// master = bridge side, slave = codec/filter side.
interface audio_sample_bridge_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              audio_in_available;
  logic [DATA_W-1:0] left_channel_codec_in;
  logic [DATA_W-1:0] right_channel_codec_in;
  logic              read_audio_in;
  logic [DATA_W-1:0] left_channel_audio_in;
  logic [DATA_W-1:0] right_channel_audio_in;
  logic              sample_strobe;
  logic [DATA_W-1:0] left_channel_audio_out;
  logic [DATA_W-1:0] right_channel_audio_out;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [DATA_W-1:0] left_channel_codec_out;
  logic [DATA_W-1:0] right_channel_codec_out;
  logic [LVL_W-1:0]  fifo_level;
  logic [15:0]       stall_count;

  modport master (
    input  audio_in_available, left_channel_codec_in, right_channel_codec_in,
    input  left_channel_audio_out, right_channel_audio_out, audio_out_allowed,
    output read_audio_in, left_channel_audio_in, right_channel_audio_in, sample_strobe,
    output write_audio_out, left_channel_codec_out, right_channel_codec_out,
    output fifo_level, stall_count
  );

  modport slave (
    output audio_in_available, left_channel_codec_in, right_channel_codec_in,
    output left_channel_audio_out, right_channel_audio_out, audio_out_allowed,
    input  read_audio_in, left_channel_audio_in, right_channel_audio_in, sample_strobe,
    input  write_audio_out, left_channel_codec_out, right_channel_codec_out,
    input  fifo_level, stall_count
  );
endinterface

// File: rtl/audio_sample_bridge.sv
// Pops one stereo sample from the codec ADC FIFO, holds it on the filter bank for a settle time,
// captures the filter result into a small output FIFO and drains that FIFO into the codec DAC.
module audio_sample_bridge #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  audio_sample_bridge_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic [DATA_W-1:0]  r_in_l;
  logic [DATA_W-1:0]  r_in_r;
  logic               r_strobe;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [15:0]        r_stall;
  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic                w_full;
  logic                w_pop_in;
  logic                w_push;
  logic                w_drain;
  logic                w_stall;
  logic [2*DATA_W-1:0] w_head;

  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The ADC pop is held off while reset is asserted so nothing leaves the codec during reset.
  always_comb begin
    w_state_next = r_state;
    w_pop_in     = 1'b0;
    w_push       = 1'b0;
    w_stall      = 1'b0;
    w_drain      = (r_level != '0) && bus.audio_out_allowed;
    case (r_state)
      S_IDLE: begin
        if (bus.audio_in_available && !w_full && !reset) begin
          w_pop_in     = 1'b1;
          w_state_next = S_SETTLE;
        end
        w_stall = bus.audio_in_available && w_full;
      end
      S_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_push       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_in_l       <= '0;
      r_in_r       <= '0;
      r_strobe     <= 1'b0;
      r_settle_cnt <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_stall      <= '0;
    end else begin
      r_strobe <= w_pop_in;
      if (w_pop_in) begin
        r_in_l       <= bus.left_channel_codec_in;
        r_in_r       <= bus.right_channel_codec_in;
        r_settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and drain leave the occupancy unchanged.
      case ({w_push, w_drain})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_stall && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.left_channel_audio_out, bus.right_channel_audio_out};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.read_audio_in           = w_pop_in;
  assign bus.left_channel_audio_in   = r_in_l;
  assign bus.right_channel_audio_in  = r_in_r;
  assign bus.sample_strobe           = r_strobe;
  assign bus.write_audio_out         = w_drain;
  assign bus.left_channel_codec_out  = (r_level != '0) ? w_head[2*DATA_W-1:DATA_W] : '0;
  assign bus.right_channel_codec_out = (r_level != '0) ? w_head[DATA_W-1:0] : '0;
  assign bus.fifo_level              = r_level;
  assign bus.stall_count             = r_stall;
endmodule
